// File: rtl/cordic_sched.sv
// cordic_sched: round-robin scheduler that shares one iterative CORDIC core
// between NREQ requesters.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req, i_req_angle    per-requester request level and flattened angles
//                         (requester k at bits [k*W +: W])
//   o_req_ack             one-hot, one-cycle grant pulse
//   o_core_start          one-cycle start pulse to the core
//   o_core_angle          angle to the core, held from start until done
//   o_core_rst            core reset: i_rst or the hung-core recovery pulse
//   i_core_done           core done (level or pulse), sampled only in WAIT
//   i_core_sin/cos        core results
//   o_rsp_valid/id/sin/cos/err, i_rsp_ready
//                         response port; err=1 for out-of-range or timeout
module cordic_sched #(
  parameter int unsigned   W         = 30,
  parameter int unsigned   NREQ      = 4,
  parameter int unsigned   IDW       = 2,
  parameter logic [W-1:0]  MAX_ANGLE = 30'h1921fc08,
  parameter int unsigned   TIMEOUT   = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*W-1:0] i_req_angle,
  output logic [NREQ-1:0]   o_req_ack,
  output logic              o_core_start,
  output logic [W-1:0]      o_core_angle,
  output logic              o_core_rst,
  input  logic              i_core_done,
  input  logic [W-1:0]      i_core_sin,
  input  logic [W-1:0]      i_core_cos,
  output logic              o_rsp_valid,
  output logic [IDW-1:0]    o_rsp_id,
  output logic [W-1:0]      o_rsp_sin,
  output logic [W-1:0]      o_rsp_cos,
  output logic              o_rsp_err,
  input  logic              i_rsp_ready
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RECOVER,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rec_q, rec_d;

  logic [NREQ-1:0] ack_d;
  logic            start_d;
  logic [W-1:0]    angle_d;
  logic            valid_d;
  logic [IDW-1:0]  rsp_id_d;
  logic [W-1:0]    sin_d, cos_d;
  logic            err_d;

  // Round-robin pick: lowest set request at or above the pointer, else the
  // lowest set request overall (the wrap-around case).
  logic            any_req, hi_hit;
  logic [IDW-1:0]  hi_id, lo_id, grant_id, ptr_next;
  logic [W-1:0]    grant_angle;

  always_comb begin
    any_req = 1'b0;
    hi_hit  = 1'b0;
    hi_id   = '0;
    lo_id   = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (i_req[IDW'(k)]) begin
        any_req = 1'b1;
        lo_id   = IDW'(k);
        if (IDW'(k) >= ptr_q) begin
          hi_hit = 1'b1;
          hi_id  = IDW'(k);
        end
      end
    end
    grant_id = hi_hit ? hi_id : lo_id;
    ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
  end

  // Angle of the winning requester.
  always_comb begin
    grant_angle = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (grant_id == IDW'(k)) grant_angle = i_req_angle[k*W +: W];
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and next register values; every register holds by default.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    rec_d    = 1'b0;
    ack_d    = '0;
    start_d  = 1'b0;
    angle_d  = o_core_angle;
    valid_d  = o_rsp_valid;
    rsp_id_d = o_rsp_id;
    sin_d    = o_rsp_sin;
    cos_d    = o_rsp_cos;
    err_d    = o_rsp_err;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          ptr_d    = ptr_next;
          ack_d    = NREQ'(1) << grant_id;
          rsp_id_d = grant_id;
          if (grant_angle <= MAX_ANGLE) begin
            state_d = S_ISSUE;
            start_d = 1'b1;
            angle_d = grant_angle;
          end else begin
            // Out of range: answer immediately, the core is never touched.
            state_d = S_RESP;
            valid_d = 1'b1;
            sin_d   = '0;
            cos_d   = '0;
            err_d   = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end

      S_WAIT: begin
        if (i_core_done) begin
          state_d = S_RESP;
          valid_d = 1'b1;
          sin_d   = i_core_sin;
          cos_d   = i_core_cos;
          err_d   = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_RECOVER;
          cnt_d   = '0;
          rec_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Two-cycle core reset, then report the timeout.
      S_RECOVER: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_RESP;
          valid_d = 1'b1;
          sin_d   = '0;
          cos_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          rec_d = 1'b1;
        end
      end

      S_RESP: begin
        if (i_rsp_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q        <= '0;
      cnt_q        <= '0;
      rec_q        <= 1'b0;
      o_req_ack    <= '0;
      o_core_start <= 1'b0;
      o_core_angle <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_id     <= '0;
      o_rsp_sin    <= '0;
      o_rsp_cos    <= '0;
      o_rsp_err    <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      rec_q        <= rec_d;
      o_req_ack    <= ack_d;
      o_core_start <= start_d;
      o_core_angle <= angle_d;
      o_rsp_valid  <= valid_d;
      o_rsp_id     <= rsp_id_d;
      o_rsp_sin    <= sin_d;
      o_rsp_cos    <= cos_d;
      o_rsp_err    <= err_d;
    end
  end

  // The core must also be held in reset while the scheduler itself is.
  assign o_core_rst = i_rst | rec_q;

endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: randomized self-checking bench for cordic_sched with a
// stub CORDIC core and a transaction-level reference model.
module tb_cordic_sched;

  localparam int unsigned  W         = 30;
  localparam int unsigned  NREQ      = 4;
  localparam int unsigned  IDW       = 2;
  localparam int unsigned  TIMEOUT   = 64;
  localparam logic [W-1:0] MAX_ANGLE = 30'h1921fc08;

  logic              i_clk       = 1'b0;
  logic              i_rst       = 1'b1;
  logic [NREQ-1:0]   i_req       = '0;
  logic [NREQ*W-1:0] i_req_angle = '0;
  logic [NREQ-1:0]   o_req_ack;
  logic              o_core_start;
  logic [W-1:0]      o_core_angle;
  logic              o_core_rst;
  logic              i_core_done = 1'b0;
  logic [W-1:0]      i_core_sin  = '0;
  logic [W-1:0]      i_core_cos  = '0;
  logic              o_rsp_valid;
  logic [IDW-1:0]    o_rsp_id;
  logic [W-1:0]      o_rsp_sin;
  logic [W-1:0]      o_rsp_cos;
  logic              o_rsp_err;
  logic              i_rsp_ready = 1'b0;

  cordic_sched #(
    .W(W), .NREQ(NREQ), .IDW(IDW), .MAX_ANGLE(MAX_ANGLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_req_angle(i_req_angle),
    .o_req_ack(o_req_ack), .o_core_start(o_core_start), .o_core_angle(o_core_angle),
    .o_core_rst(o_core_rst), .i_core_done(i_core_done), .i_core_sin(i_core_sin),
    .i_core_cos(i_core_cos), .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id),
    .o_rsp_sin(o_rsp_sin), .o_rsp_cos(o_rsp_cos), .o_rsp_err(o_rsp_err),
    .i_rsp_ready(i_rsp_ready)
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Stub core transfer functions.
  function automatic logic [W-1:0] core_sin(input logic [W-1:0] a);
    return a ^ 30'h15555555;
  endfunction
  function automatic logic [W-1:0] core_cos(input logic [W-1:0] a);
    return {a[W/2-1:0], a[W-1:W/2]} + W'(7);
  endfunction

  // Reference arbiter: first requester at or after p, wrapping.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    int idx;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = (p + i) % int'(NREQ);
      if (r[IDW'(idx)]) return idx;
    end
    return -1;
  endfunction

  // Model state: at most one transaction is ever in flight.
  int              ptr_m      = 0;
  logic [NREQ-1:0] pend       = '0;
  bit              model_idle = 1'b1;
  bit              going_idle = 1'b0;
  bit              cur_valid  = 1'b0;
  int              cur_id     = 0;
  logic [W-1:0]    cur_ang    = '0;
  bit              cur_rej    = 1'b0;
  bit              cur_hang   = 1'b0;
  bit              cur_started = 1'b0;
  int              cur_ack    = 0;
  int              cur_st     = 0;
  int              cur_lat    = 1;
  int              cur_rst_ticks = 0;

  bit              force_hang = 1'b0;
  bit              rand_hang  = 1'b0;
  int              rdy_mode   = 0;   // 0 ready, 1 random, 2 held low
  int              fix_lat    = 3;   // 0 = random latency per transaction

  logic [W-1:0]    stub_ang   = '0;
  int              stub_cd    = 0;

  bit              prev_valid = 1'b0;
  bit              prev_hs    = 1'b0;
  logic [62:0]     prev_rsp   = '0;

  task automatic post(input int k, input logic [W-1:0] a);
    pend[IDW'(k)]         = 1'b1;
    i_req[IDW'(k)]        = 1'b1;
    i_req_angle[k*W +: W] = a;
  endtask

  function automatic logic [W-1:0] rand_angle();
    case ($urandom_range(0, 3))
      0:       return MAX_ANGLE;
      1:       return MAX_ANGLE + W'(1);
      2:       return W'($urandom);
      default: return W'($urandom_range(0, 32'(MAX_ANGLE)));
    endcase
  endfunction

  // One clock: sample at the falling edge, check, then drive the next inputs.
  task automatic tick();
    logic [62:0] rsp_now;
    int          exp_id;
    int          exp_cyc;
    bit          hs;
    @(negedge i_clk);
    cyc++;
    rsp_now = {o_rsp_id, o_rsp_err, o_rsp_sin, o_rsp_cos};

    if (i_rst) begin
      check_eq("rst_ctrl", 64'({o_req_ack, o_core_start, o_rsp_valid, o_core_rst}), 64'({4'b0, 1'b0, 1'b0, 1'b1}));
      check_eq("rst_angle", 64'(o_core_angle), 64'(0));
      check_eq("rst_rsp", 64'(rsp_now), 64'(0));
      ptr_m       = 0;
      pend        = '0;
      i_req       = '0;
      model_idle  = 1'b1;
      going_idle  = 1'b0;
      cur_valid   = 1'b0;
      stub_cd     = 0;
      i_core_done = 1'b0;
      prev_valid  = 1'b0;
      prev_hs     = 1'b0;
      return;
    end

    if (model_idle && i_req != '0)
      check_eq("grant_missing", 64'(o_req_ack != '0), 64'(1));

    if (o_req_ack != '0) begin
      check_eq("ack_when_busy", 64'(model_idle), 64'(1));
      exp_id = pick(i_req, ptr_m);
      check_eq("ack_onehot", 64'(o_req_ack), (exp_id < 0) ? 64'(0) : (64'(1) << exp_id));
      if (exp_id >= 0) begin
        model_idle    = 1'b0;
        cur_valid     = 1'b1;
        cur_id        = exp_id;
        cur_ang       = i_req_angle[exp_id*W +: W];
        cur_rej       = (cur_ang > MAX_ANGLE);
        cur_hang      = !cur_rej && (force_hang || (rand_hang && $urandom_range(0, 7) == 0));
        cur_started   = 1'b0;
        cur_ack       = cyc;
        cur_st        = -1000;
        cur_rst_ticks = 0;
        cur_lat       = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 6));
        ptr_m         = (exp_id + 1) % int'(NREQ);
        pend[IDW'(exp_id)] = 1'b0;
      end
    end

    if (o_core_start) begin
      check_eq("start_expected", 64'(cur_valid && !cur_rej && !cur_started), 64'(1));
      check_eq("start_timing", 64'(cyc - cur_ack), 64'(0));
      check_eq("start_angle", 64'(o_core_angle), 64'(cur_ang));
      cur_started = 1'b1;
      cur_st      = cyc;
    end

    if (o_core_rst) begin
      check_eq("core_rst_window", 64'(cur_valid && cur_hang &&
               ((cyc - cur_st) == int'(TIMEOUT) + 1 || (cyc - cur_st) == int'(TIMEOUT) + 2)), 64'(1));
      cur_rst_ticks++;
    end

    if (prev_valid && !prev_hs) begin
      check_eq("valid_held", 64'(o_rsp_valid), 64'(1));
      check_eq("rsp_stable", 64'(rsp_now), 64'(prev_rsp));
    end
    if (prev_hs) check_eq("valid_drop", 64'(o_rsp_valid), 64'(0));
    if (o_rsp_valid && !prev_valid) begin
      check_eq("rsp_owner", 64'(cur_valid), 64'(1));
      exp_cyc = cur_rej  ? cur_ack :
                cur_hang ? cur_st + int'(TIMEOUT) + 3 :
                           cur_st + cur_lat + 1;
      check_eq("rsp_latency", 64'(cyc), 64'(exp_cyc));
    end

    if (going_idle) begin
      model_idle = 1'b1;
      going_idle = 1'b0;
    end

    // Drive requests, ready and the stub core.
    i_req = pend;
    case (rdy_mode)
      0:       i_rsp_ready = 1'b1;
      1:       i_rsp_ready = 1'($urandom_range(0, 1));
      default: i_rsp_ready = 1'b0;
    endcase
    if (o_core_rst) begin
      stub_cd     = 0;
      i_core_done = 1'b0;
    end else if (o_core_start) begin
      stub_ang    = o_core_angle;
      stub_cd     = cur_hang ? 0 : cur_lat;
      i_core_done = 1'($urandom_range(0, 1));  // junk during the start cycle
    end else if (stub_cd > 0) begin
      stub_cd--;
      i_core_done = (stub_cd == 0);
    end else begin
      i_core_done = 1'b0;
    end
    i_core_sin = core_sin(stub_ang);
    i_core_cos = core_cos(stub_ang);

    hs = o_rsp_valid && i_rsp_ready;
    if (hs) begin
      check_eq("rsp_owner_hs", 64'(cur_valid), 64'(1));
      check_eq("rsp_id", 64'(o_rsp_id), 64'(cur_id));
      check_eq("rsp_err", 64'(o_rsp_err), 64'(cur_rej || cur_hang));
      check_eq("rsp_sin", 64'(o_rsp_sin), (cur_rej || cur_hang) ? 64'(0) : 64'(core_sin(cur_ang)));
      check_eq("rsp_cos", 64'(o_rsp_cos), (cur_rej || cur_hang) ? 64'(0) : 64'(core_cos(cur_ang)));
      check_eq("core_used", 64'(cur_started), 64'(!cur_rej));
      if (cur_hang) check_eq("recover_len", 64'(cur_rst_ticks), 64'(2));
      cur_valid  = 1'b0;
      going_idle = 1'b1;
    end
    prev_valid = o_rsp_valid;
    prev_hs    = hs;
    prev_rsp   = rsp_now;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((pend != '0 || cur_valid) && n < 3000) begin
      tick();
      n++;
    end
    check_eq(tag, 64'(pend != '0 || cur_valid), 64'(0));
    tick();
    tick();
  endtask

  initial begin
    int n;
    i_rst = 1'b1;
    repeat (3) tick();
    i_rst = 1'b0;

    // All four at once from pointer 0: served 0,1,2,3.
    for (int k = 0; k < int'(NREQ); k++) post(k, W'((k + 1) * 256));
    drain("drain_all4");

    post(1, '0);
    drain("drain_single");

    // Range boundary.
    post(2, MAX_ANGLE + W'(1));
    drain("drain_reject");
    post(2, MAX_ANGLE);
    drain("drain_max");

    // Hung core, then a normal transaction.
    force_hang = 1'b1;
    post(0, 30'h000c0ffe);
    drain("drain_hang");
    force_hang = 1'b0;
    post(3, 30'h00100000);
    drain("drain_after_hang");

    // Back-pressure with a competing request queued.
    rdy_mode = 2;
    post(1, 30'h00123456);
    n = 0;
    while (!o_rsp_valid && n < 200) begin
      tick();
      n++;
    end
    check_eq("bp_valid", 64'(o_rsp_valid), 64'(1));
    post(2, 30'h00000777);
    repeat (20) tick();
    check_eq("bp_still_valid", 64'(o_rsp_valid), 64'(1));
    check_eq("bp_no_ack", 64'(pend[2]), 64'(1));
    rdy_mode = 0;
    drain("drain_bp");

    // Randomized traffic.
    rdy_mode  = 1;
    fix_lat   = 0;
    rand_hang = 1'b1;
    repeat (1500) begin
      for (int k = 0; k < int'(NREQ); k++)
        if (!pend[IDW'(k)] && $urandom_range(0, 9) == 0) post(k, rand_angle());
      tick();
    end
    rand_hang = 1'b0;
    rdy_mode  = 0;
    drain("drain_random");

    // Reset while waiting on the core; pointer must return to 0.
    fix_lat    = 3;
    force_hang = 1'b1;
    post(1, 30'h00abcdef);
    n = 0;
    while (!cur_started && n < 50) begin
      tick();
      n++;
    end
    check_eq("rst_test_started", 64'(cur_started), 64'(1));
    repeat (5) tick();
    force_hang = 1'b0;
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    post(0, 30'h00000aaa);
    post(2, 30'h00000bbb);
    drain("drain_post_rst");
    post(3, 30'h00000ccc);
    drain("drain_req3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_sched.md
Name: cordic_sched

Overview:
- Shares one 30-bit iterative cordic core between NREQ requesters using round-robin arbitration.
- Sequences the core's start/done handshake and returns sin/cos to the winning requester over a valid/ready response port, tagged with the requester id.
- Rejects out-of-range angles without using the core.
- Recovers a hung core with a timeout and a core reset pulse.

Parameters:
- W, 30, angle/sin/cos width.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester id width (clog2 NREQ).
- MAX_ANGLE, 30'h1921fc08, largest legal angle (pi/2).
- TIMEOUT, 64, max cycles in WAIT before abort (>=2).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_req  in  NREQ  per-requester request level; held until acked.
- i_req_angle  in  NREQ*W  flattened angles; requester k at bits [k*W +: W].
- o_req_ack  out  NREQ  one-hot, 1-cycle grant/ack pulse.
- o_core_start  out  1  1-cycle start pulse to core.
- o_core_angle  out  W  angle to core; stable from start until done.
- o_core_rst  out  1  core reset = i_rst OR recovery pulse.
- i_core_done  in  1  core done (level or pulse).
- i_core_sin  in  W  core sine.
- i_core_cos  in  W  core cosine.
- o_rsp_valid  out  1  response valid.
- o_rsp_id  out  IDW  requester id of response.
- o_rsp_sin  out  W  result sine.
- o_rsp_cos  out  W  result cosine.
- o_rsp_err  out  1  1 = out-of-range or timeout; sin/cos are 0.
- i_rsp_ready  in  1  response consumer ready.

Behaviour:
- Reset (i_rst=1 at edge):
  - state IDLE, rr pointer 0, timeout counter 0.
  - All registered outputs 0: o_req_ack, o_core_start, o_core_angle, o_rsp_*.
  - o_core_rst=1 while i_rst=1.
  - Reset mid-operation abandons the transaction; no response is issued.
- FSM states: IDLE, ISSUE, WAIT, RECOVER, RESP.
- IDLE:
  - If any i_req: pick the first set bit searching from the rr pointer upward, wrapping.
  - At that edge: latch id and angle, pulse o_req_ack[id] next cycle, set pointer = (id+1) mod NREQ.
  - If angle <= MAX_ANGLE, go to ISSUE.
  - Else go to RESP with err=1, sin=cos=0; the core is untouched.
  - No request: stay in IDLE.
- ISSUE: o_core_start=1 for exactly this cycle; o_core_angle = latched angle. Go to WAIT; clear counter.
- WAIT:
  - i_core_done ignored in the ISSUE cycle; sampled only in WAIT.
  - Done=1: capture i_core_sin/cos into o_rsp_sin/cos, err=0, go to RESP.
  - Otherwise counter++.
  - Counter reaching TIMEOUT-1 without done: go to RECOVER.
- RECOVER: o_core_rst=1 for 2 cycles, then RESP with err=1, sin=cos=0.
- RESP:
  - o_rsp_valid=1; id, sin, cos, err stable until the handshake.
  - When valid & i_rsp_ready: valid drops next cycle, go to IDLE.
- Arbitration happens only in IDLE. Requests arriving while busy wait; i_req must stay high until ack.
- Requester drops i_req the cycle after seeing ack. The controller ignores i_req until it returns to IDLE.
- Nominal latency, core latency L = cycles from start to done: ack at T+1, start at T+1, done sampled ~T+1+L, rsp_valid the cycle after.
- Back-to-back: next grant evaluated in the first IDLE cycle after the response handshake.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,2,3,0… Each requester waits at most NREQ-1 transactions.
- Angle compare is unsigned W-bit. MAX_ANGLE itself is legal.

Test Plan:
- Single request 1, angle 30'h0 -> ack[1] pulse; one core start with o_core_angle=0; response id=1, err=0, sin/cos equal the core outputs.
- All 4 requesting, angles 0x100/0x200/0x300/0x400, i_rsp_ready=1 -> responses in id order 0,1,2,3, each carrying its own angle's result; exactly one start per response.
- Req 2, angle 30'h1921fc09 -> ack, no o_core_start, response id=2, err=1, sin=cos=0. Angle 30'h1921fc08 -> accepted, err=0.
- Core stubbed never asserting done, TIMEOUT=64 -> o_core_rst high 2 cycles after 64 WAIT cycles, then response err=1; the next request completes normally.
- i_rsp_ready held 0 for 20 cycles while RESP is pending -> valid/id/sin/cos stable the whole time, no new ack or start. Raise ready -> single handshake.
- i_rst pulsed during WAIT -> all outputs 0, no response, pointer 0; after release, req 3 alone is served with id=3.
